// File: rtl/cw310_reg_master.sv
// cw310_reg_master
// Register-bus initiator: turns a byte-serial command stream into register-bus
// transactions and returns read data plus one status byte per command.
//
// Command: opcode {dir(1=read), N-1[6:0]}, ceil(AW/8) little-endian address
// bytes, then N data bytes for writes. Reads return N data bytes before the
// status byte. Status 8'h00 = OK, 8'h01 = timeout.
//
// Ports:
//   usb_clk, reset_n (synchronous, active-low)
//   cmd_data/cmd_valid/cmd_ready  : command byte stream in
//   rsp_data/rsp_valid/rsp_ready  : response byte stream out
//   reg_address, reg_bytecnt, write_data, read_data,
//   reg_read, reg_write, reg_addrvalid : register bus
//   O_busy                        : high whenever the state is not IDLE
//
// Optional feature: define REG_MASTER_TIMEOUT_EN to abort a command that stalls
// for pTIMEOUT cycles in ADDR/WDATA; it then reports status 8'h01.
module cw310_reg_master #(
    parameter int pADDR_WIDTH    = 21,
    parameter int pBYTECNT_SIZE  = 7,
    parameter int pREAD_LATENCY  = 0,
    parameter int pTIMEOUT       = 65535
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_n,
    input  logic [7:0]                           cmd_data,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    output logic [7:0]                           rsp_data,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           write_data,
    input  logic [7:0]                           read_data,
    output logic                                 reg_write,
    output logic                                 reg_read,
    output logic                                 reg_addrvalid,
    output logic                                 O_busy
);

    localparam int AW         = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int ADDR_BYTES = (AW + 7) / 8;
    localparam int ABW        = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int LATW       = (pREAD_LATENCY > 0) ? $clog2(pREAD_LATENCY + 1) : 1;
    localparam logic [ABW-1:0]  ADDR_LAST = ABW'(ADDR_BYTES - 1);
    localparam logic [LATW-1:0] LAT_LAST  = LATW'(pREAD_LATENCY);
    localparam logic [7:0]      STAT_OK      = 8'h00;
    localparam logic [7:0]      STAT_TIMEOUT = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WDATA   = 3'd2,
        S_WSTROBE = 3'd3,
        S_RSTROBE = 3'd4,
        S_RSEND   = 3'd5,
        S_STATUS  = 3'd6
    } state_t;

    state_t                   state_r, state_next_s;
    logic                     dir_r, dir_next_s;
    logic [6:0]               n_r, n_next_s;
    logic [ABW-1:0]           addr_idx_r, addr_idx_next_s;
    logic [ADDR_BYTES*8-1:0]  addr_shift_r, addr_shift_next_s;
    logic [(ADDR_BYTES+1)*8-1:0] addr_cat_s;
    logic [ADDR_BYTES*8-1:0]  addr_full_s;
    logic [LATW-1:0]          lat_cnt_r, lat_next_s;
    logic [AW-1:0]            address_next_s;
    logic [pBYTECNT_SIZE-1:0] bytecnt_next_s;
    logic [7:0]               wdata_next_s;
    logic [7:0]               rsp_data_next_s;
    logic                     cmd_fire_s, rsp_fire_s, last_byte_s, timeout_s;

`ifdef REG_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(pTIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(pTIMEOUT - 1);
    logic [TW-1:0] tmo_cnt_r;

    // Idle-cycle counter for ADDR/WDATA; cleared by every accepted byte.
    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if ((state_r == S_ADDR || state_r == S_WDATA) && !cmd_fire_s && !timeout_s) begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
        end else begin
            tmo_cnt_r <= {TW{1'b0}};
        end
    end
`endif

    assign cmd_fire_s  = cmd_valid & cmd_ready;
    assign rsp_fire_s  = rsp_valid & rsp_ready;
    assign last_byte_s = (int'(reg_bytecnt) == int'(n_r));
    // New address byte enters at the top, so byte 0 ends up in the low bits.
    assign addr_cat_s  = {cmd_data, addr_shift_r};
    assign addr_full_s = addr_cat_s[(ADDR_BYTES+1)*8-1:8];

    // Next-state and next-output computation.
    always_comb begin
        state_next_s      = state_r;
        dir_next_s        = dir_r;
        n_next_s          = n_r;
        addr_idx_next_s   = addr_idx_r;
        addr_shift_next_s = addr_shift_r;
        lat_next_s        = lat_cnt_r;
        address_next_s    = reg_address;
        bytecnt_next_s    = reg_bytecnt;
        wdata_next_s      = write_data;
        rsp_data_next_s   = rsp_data;

`ifdef REG_MASTER_TIMEOUT_EN
        timeout_s = (state_r == S_ADDR || state_r == S_WDATA) && !cmd_fire_s
                    && (tmo_cnt_r == TMO_LAST);
`else
        timeout_s = 1'b0;
`endif

        if (timeout_s) begin
            state_next_s    = S_STATUS;
            rsp_data_next_s = STAT_TIMEOUT;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_fire_s) begin
                        dir_next_s      = cmd_data[7];
                        n_next_s        = cmd_data[6:0];
                        addr_idx_next_s = {ABW{1'b0}};
                        state_next_s    = S_ADDR;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_ADDR: begin
                    if (cmd_fire_s) begin
                        addr_shift_next_s = addr_full_s;
                        if (addr_idx_r == ADDR_LAST) begin
                            address_next_s = addr_full_s[AW-1:0];
                            bytecnt_next_s = {pBYTECNT_SIZE{1'b0}};
                            lat_next_s     = {LATW{1'b0}};
                            state_next_s   = dir_r ? S_RSTROBE : S_WDATA;
                        end else begin
                            addr_idx_next_s = addr_idx_r + 1'b1;
                        end
                    end else begin
                        state_next_s = S_ADDR;
                    end
                end
                S_WDATA: begin
                    if (cmd_fire_s) begin
                        wdata_next_s = cmd_data;
                        state_next_s = S_WSTROBE;
                    end else begin
                        state_next_s = S_WDATA;
                    end
                end
                S_WSTROBE: begin
                    // bytecnt is held on the last byte so N=128 never wraps.
                    if (last_byte_s) begin
                        rsp_data_next_s = STAT_OK;
                        state_next_s    = S_STATUS;
                    end else begin
                        bytecnt_next_s = reg_bytecnt + 1'b1;
                        state_next_s   = S_WDATA;
                    end
                end
                S_RSTROBE: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        rsp_data_next_s = read_data;
                        state_next_s    = S_RSEND;
                    end else begin
                        lat_next_s = lat_cnt_r + 1'b1;
                    end
                end
                S_RSEND: begin
                    if (rsp_fire_s && last_byte_s) begin
                        rsp_data_next_s = STAT_OK;
                        state_next_s    = S_STATUS;
                    end else if (rsp_fire_s) begin
                        bytecnt_next_s = reg_bytecnt + 1'b1;
                        lat_next_s     = {LATW{1'b0}};
                        state_next_s   = S_RSTROBE;
                    end else begin
                        state_next_s = S_RSEND;
                    end
                end
                S_STATUS: begin
                    if (rsp_fire_s) begin
                        state_next_s = S_IDLE;
                    end else begin
                        state_next_s = S_STATUS;
                    end
                end
                default: begin
                    state_next_s = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered-output update; strobes decode the next state.
    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            state_r       <= S_IDLE;
            dir_r         <= 1'b0;
            n_r           <= 7'd0;
            addr_idx_r    <= {ABW{1'b0}};
            addr_shift_r  <= {(ADDR_BYTES*8){1'b0}};
            lat_cnt_r     <= {LATW{1'b0}};
            reg_address   <= {AW{1'b0}};
            reg_bytecnt   <= {pBYTECNT_SIZE{1'b0}};
            write_data    <= 8'h00;
            rsp_data      <= 8'h00;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            reg_write     <= 1'b0;
            reg_read      <= 1'b0;
            reg_addrvalid <= 1'b0;
            O_busy        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            dir_r         <= dir_next_s;
            n_r           <= n_next_s;
            addr_idx_r    <= addr_idx_next_s;
            addr_shift_r  <= addr_shift_next_s;
            lat_cnt_r     <= lat_next_s;
            reg_address   <= address_next_s;
            reg_bytecnt   <= bytecnt_next_s;
            write_data    <= wdata_next_s;
            rsp_data      <= rsp_data_next_s;
            cmd_ready     <= (state_next_s == S_IDLE) || (state_next_s == S_ADDR)
                             || (state_next_s == S_WDATA);
            rsp_valid     <= (state_next_s == S_RSEND) || (state_next_s == S_STATUS);
            reg_write     <= (state_next_s == S_WSTROBE);
            reg_read      <= (state_next_s == S_RSTROBE);
            reg_addrvalid <= (state_next_s == S_WDATA) || (state_next_s == S_WSTROBE)
                             || (state_next_s == S_RSTROBE) || (state_next_s == S_RSEND);
            O_busy        <= (state_next_s != S_IDLE);
        end
    end

endmodule

// File: tb/tb_cw310_reg_master.sv
// Directed self-checking bench for cw310_reg_master (pREAD_LATENCY=1,
// pTIMEOUT=16). The responder returns 8'h10+bytecnt one cycle after reg_read
// and 8'hEE otherwise, so an early capture shows up as a wrong byte.
module tb_cw310_reg_master;

    logic        usb_clk = 1'b0;
    logic        reset_n;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [13:0] reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        reg_write;
    logic        reg_read;
    logic        reg_addrvalid;
    logic        O_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    cw310_reg_master #(
        .pADDR_WIDTH   (21),
        .pBYTECNT_SIZE (7),
        .pREAD_LATENCY (1),
        .pTIMEOUT      (16)
    ) dut (
        .usb_clk       (usb_clk),
        .reset_n       (reset_n),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .rsp_data      (rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .write_data    (write_data),
        .read_data     (read_data),
        .reg_write     (reg_write),
        .reg_read      (reg_read),
        .reg_addrvalid (reg_addrvalid),
        .O_busy        (O_busy)
    );

    always #5 usb_clk = ~usb_clk;

    // Latency-1 responder
    logic [7:0] rd_q = 8'hEE;
    always @(posedge usb_clk) rd_q <= reg_read ? (8'h10 + {1'b0, reg_bytecnt}) : 8'hEE;
    assign read_data = rd_q;

    // Bus monitor
    logic [6:0]  wr_bc[$];
    logic [7:0]  wr_dat[$];
    logic [13:0] wr_adr[$];
    int rd_runs[$];
    int rd_run = 0;
    int strobe_err = 0;
    always @(negedge usb_clk) begin
        if (reg_write) begin
            wr_bc.push_back(reg_bytecnt);
            wr_dat.push_back(write_data);
            wr_adr.push_back(reg_address);
        end
        if (reg_read) rd_run++;
        else if (rd_run != 0) begin
            rd_runs.push_back(rd_run);
            rd_run = 0;
        end
        if ((reg_read && reg_write) || ((reg_read || reg_write) && !reg_addrvalid))
            strobe_err++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge usb_clk);
            n++;
        end
        if (n >= 200) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte_timeout: cmd_ready stayed %b, want 1", cmd_ready);
        end
        @(posedge usb_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic [6:0] bc);
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge usb_clk);
            n++;
        end
        if (n >= 200) begin
            tests_run++;
            tests_failed++;
            $display("FAIL recv_byte_timeout: rsp_valid stayed %b, want 1", rsp_valid);
        end
        b  = rsp_data;
        bc = reg_bytecnt;
        @(posedge usb_clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(posedge usb_clk);
        #1;
        tests_run++;
        if ({cmd_ready, rsp_valid, reg_read, reg_write, reg_addrvalid, O_busy,
             rsp_data, write_data, reg_address, reg_bytecnt} !== 43'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got %h, want 0", {cmd_ready, rsp_valid, reg_read,
                     reg_write, reg_addrvalid, O_busy, rsp_data, write_data, reg_address, reg_bytecnt});
        end
        @(negedge usb_clk);
        reset_n = 1'b1;
        @(posedge usb_clk);
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1 || O_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: cmd_ready=%b O_busy=%b, want 1 0", cmd_ready, O_busy);
        end
    endtask

    task automatic test_write();
        logic [7:0] b;
        logic [6:0] bc;
        wr_bc.delete(); wr_dat.delete(); wr_adr.delete();
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'hAA);
        tests_run++;
        if (reg_write !== 1'b1 || cmd_ready !== 1'b0 || reg_bytecnt !== 7'd0 || write_data !== 8'hAA) begin
            tests_failed++;
            $display("FAIL write_strobe_timing: wr=%b rdy=%b bc=%0d wd=%h, want 1 0 0 aa",
                     reg_write, cmd_ready, reg_bytecnt, write_data);
        end
        send_byte(8'h55);
        recv_byte(b, bc);
        tests_run++;
        if (b !== 8'h00) begin
            tests_failed++;
            $display("FAIL write_status: got %h, want 00", b);
        end
        tests_run++;
        if (wr_bc.size() != 2) begin
            tests_failed++;
            $display("FAIL write_pulses: got %0d pulses, want 2", wr_bc.size());
        end else if (wr_bc[0] !== 7'd0 || wr_dat[0] !== 8'hAA || wr_bc[1] !== 7'd1 ||
                     wr_dat[1] !== 8'h55 || wr_adr[0] !== 14'h0005 || wr_adr[1] !== 14'h0005) begin
            tests_failed++;
            $display("FAIL write_pulses: got (%0d,%h,%h) (%0d,%h,%h), want (0,aa,0005) (1,55,0005)",
                     wr_bc[0], wr_dat[0], wr_adr[0], wr_bc[1], wr_dat[1], wr_adr[1]);
        end
    endtask

    task automatic test_read_latency();
        logic [7:0] b;
        logic [6:0] bc;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h10; exp_b[1] = 8'h11; exp_b[2] = 8'h12; exp_b[3] = 8'h13;
        rd_runs.delete();
        send_byte(8'h83);
        send_byte(8'h34);
        send_byte(8'h12);
        tests_run++;
        if (reg_read !== 1'b1 || rsp_valid !== 1'b0 || reg_address !== 14'h1234 || reg_bytecnt !== 7'd0) begin
            tests_failed++;
            $display("FAIL read_start: rd=%b rv=%b addr=%h bc=%0d, want 1 0 1234 0",
                     reg_read, rsp_valid, reg_address, reg_bytecnt);
        end
        @(posedge usb_clk); #1;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_valid_early: rsp_valid=%b one cycle after reg_read, want 0", rsp_valid);
        end
        @(posedge usb_clk); #1;
        tests_run++;
        if (rsp_valid !== 1'b1 || reg_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_valid_rise: rsp_valid=%b reg_read=%b two cycles after reg_read, want 1 0",
                     rsp_valid, reg_read);
        end
        for (int i = 0; i < 4; i++) begin
            recv_byte(b, bc);
            tests_run++;
            if (b !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL read_data_%0d: got %h, want %h", i, b, exp_b[i]);
            end
        end
        recv_byte(b, bc);
        tests_run++;
        if (b !== 8'h00) begin
            tests_failed++;
            $display("FAIL read_status: got %h, want 00", b);
        end
        tests_run++;
        if (rd_runs.size() != 4 || rd_runs[0] != 2 || rd_runs[1] != 2 || rd_runs[2] != 2 || rd_runs[3] != 2) begin
            tests_failed++;
            $display("FAIL read_strobe_len: got %0d runs (first %0d), want 4 runs of 2",
                     rd_runs.size(), (rd_runs.size() > 0) ? rd_runs[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b, held;
        logic [6:0] bc;
        int stall_bad, n;
        rsp_ready = 1'b0;
        send_byte(8'h81);
        send_byte(8'h00);
        send_byte(8'h01);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 50) begin
                @(negedge usb_clk);
                n++;
            end
            held = rsp_data;
            stall_bad = 0;
            repeat (10) begin
                @(negedge usb_clk);
                if (rsp_valid !== 1'b1 || rsp_data !== held || reg_read !== 1'b0) stall_bad++;
            end
            tests_run++;
            if (stall_bad != 0 || held !== (8'h10 + 8'(k))) begin
                tests_failed++;
                $display("FAIL stall_byte_%0d: data=%h bad_cycles=%0d, want %h 0",
                         k, held, stall_bad, 8'h10 + 8'(k));
            end
            recv_byte(b, bc);
        end
        recv_byte(b, bc);
        tests_run++;
        if (b !== 8'h00) begin
            tests_failed++;
            $display("FAIL stall_status: got %h, want 00", b);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [6:0] bc;
        int spurious;
        send_byte(8'h02);
        send_byte(8'h22);
        send_byte(8'h00);
        send_byte(8'h11);
        reset_n = 1'b0;
        @(posedge usb_clk); #1;
        tests_run++;
        if ({cmd_ready, rsp_valid, reg_read, reg_write, reg_addrvalid, O_busy,
             rsp_data, write_data, reg_address, reg_bytecnt} !== 43'd0) begin
            tests_failed++;
            $display("FAIL midreset_values: got %h, want 0", {cmd_ready, rsp_valid, reg_read,
                     reg_write, reg_addrvalid, O_busy, rsp_data, write_data, reg_address, reg_bytecnt});
        end
        reset_n = 1'b1;
        spurious = 0;
        repeat (5) begin
            @(posedge usb_clk); #1;
            if (rsp_valid !== 1'b0) spurious++;
        end
        tests_run++;
        if (spurious != 0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_no_status: rsp_valid cycles=%0d cmd_ready=%b, want 0 1", spurious, cmd_ready);
        end
        send_byte(8'h80);
        send_byte(8'h00);
        send_byte(8'h00);
        recv_byte(b, bc);
        tests_run++;
        if (b !== 8'h10) begin
            tests_failed++;
            $display("FAIL midreset_read: got %h, want 10", b);
        end
        recv_byte(b, bc);
        tests_run++;
        if (b !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset_read_status: got %h, want 00", b);
        end
    endtask

    task automatic test_read_128();
        logic [7:0] b;
        logic [6:0] bc;
        int bad;
        bad = 0;
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        for (int i = 0; i < 128; i++) begin
            recv_byte(b, bc);
            if (b !== (8'h10 + 8'(i)) || bc !== 7'(i)) begin
                bad++;
                if (bad == 1) $display("FAIL read128_byte_%0d: got %h bc %0d, want %h bc %0d",
                                       i, b, bc, 8'h10 + 8'(i), i);
            end
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL read128_data: %0d bad bytes, want 0", bad);
        end
        recv_byte(b, bc);
        tests_run++;
        if (b !== 8'h00) begin
            tests_failed++;
            $display("FAIL read128_status: got %h, want 00", b);
        end
    endtask

`ifdef REG_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] b;
        logic [6:0] bc;
        int early;
        send_byte(8'h00);
        send_byte(8'h07);
        early = 0;
        repeat (15) begin
            @(posedge usb_clk); #1;
            if (rsp_valid !== 1'b0) early++;
        end
        @(posedge usb_clk); #1;
        tests_run++;
        if (early != 0 || rsp_valid !== 1'b1 || rsp_data !== 8'h01) begin
            tests_failed++;
            $display("FAIL timeout_status: early=%0d rsp_valid=%b rsp_data=%h at cycle 16, want 0 1 01",
                     early, rsp_valid, rsp_data);
        end
        recv_byte(b, bc);
        wr_bc.delete(); wr_dat.delete(); wr_adr.delete();
        send_byte(8'h00);
        send_byte(8'h09);
        send_byte(8'h00);
        send_byte(8'h5A);
        recv_byte(b, bc);
        tests_run++;
        if (b !== 8'h00 || wr_dat.size() != 1 || wr_dat[0] !== 8'h5A || wr_adr[0] !== 14'h0009) begin
            tests_failed++;
            $display("FAIL timeout_recover: status=%h pulses=%0d, want 00 1 (5a @0009)", b, wr_dat.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_latency();
        test_backpressure();
        test_reset_mid();
        test_read_128();
`ifdef REG_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        tests_run++;
        if (strobe_err != 0) begin
            tests_failed++;
            $display("FAIL strobe_rules: %0d bad strobe cycles, want 0", strobe_err);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
